// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single RAM data port.
// It handles alignment checks, byte-lane write enables and extension of load data.
module mem_port_arbiter #(
  parameter logic [1:0] MEM_DISABLE   = 2'b00,
  parameter logic [1:0] MEM_READ_SEXT = 2'b01,
  parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
  parameter logic [1:0] MEM_WRITE     = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [3:0]  ram_web,
  output logic        ram_en,
  input  logic [31:0] ram_dout
);
  typedef struct packed {
    logic        req;
    logic [1:0]  mode;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic       vld;
    logic       owner;
    logic [1:0] size;
    logic [1:0] off;
    logic       sext;
  } pend_t;

  req_t [1:0]        rq;
  req_t              cur;
  pend_t             pend;
  logic [1:0]        act, gnt, err;
  logic              rr_ptr, sel, misal, rd_gnt;
  logic [31:0]       lane, ext;
  logic [1:0][31:0]  rdata_q;

  assign rq[0] = {req0, mode0, size0, addr0, wdata0};
  assign rq[1] = {req1, mode1, size1, addr1, wdata1};

  // rr_ptr names the requester that wins the next conflict
  always_comb begin
    for (int i = 0; i < 2; i++) act[i] = rq[i].req && (rq[i].mode != MEM_DISABLE);
    sel   = (&act) ? rr_ptr : act[1];
    cur   = rq[sel];
    misal = cur.size[1] ? (cur.addr[1:0] != 2'b00) : (cur.size[0] && cur.addr[0]);
    gnt   = '0;
    err   = '0;
    if (reset && (|act)) begin
      if (misal) err[sel] = 1'b1;
      else       gnt[sel] = 1'b1;
    end
  end

  always_comb begin
    ram_en   = |gnt;
    ram_addr = '0;
    ram_din  = '0;
    ram_web  = '0;
    if (ram_en) begin
      ram_addr = cur.addr;
      if (cur.mode == MEM_WRITE) begin
        case (cur.size)
          2'b00: begin
            ram_web = 4'b0001 << cur.addr[1:0];
            ram_din = {4{cur.wdata[7:0]}};
          end
          2'b01: begin
            ram_web = 4'b0011 << {cur.addr[1], 1'b0};
            ram_din = {2{cur.wdata[15:0]}};
          end
          default: begin
            ram_web = 4'b1111;
            ram_din = cur.wdata;
          end
        endcase
      end
    end
  end

  assign rd_gnt = ram_en && (cur.mode != MEM_WRITE);

  // Accesses are aligned, so shifting by the byte offset lands the lane at bit 0
  always_comb begin
    lane = ram_dout >> {pend.off, 3'b000};
    case (pend.size)
      2'b00:   ext = {{24{pend.sext & lane[7]}}, lane[7:0]};
      2'b01:   ext = {{16{pend.sext & lane[15]}}, lane[15:0]};
      default: ext = ram_dout;
    endcase
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign err0    = err[0];
  assign err1    = err[1];
  assign rvalid0 = pend.vld && !pend.owner;
  assign rvalid1 = pend.vld && pend.owner;
  assign rdata0  = rvalid0 ? ext : rdata_q[0];
  assign rdata1  = rvalid1 ? ext : rdata_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= 1'b0;
      pend    <= '0;
      rdata_q <= '0;
    end else begin
      if ((|gnt) || (|err)) rr_ptr <= ~sel;
      pend.vld <= rd_gnt;
      if (rd_gnt) begin
        pend.owner <= sel;
        pend.size  <= cur.size;
        pend.off   <= cur.addr[1:0];
        pend.sext  <= (cur.mode == MEM_READ_SEXT);
      end
      if (pend.vld) rdata_q[pend.owner] <= ext;
    end
  end
endmodule
